multicycle_control: RTL and testbench

Sequencing controller for the multi-cycle variant of the single-core RISC-V datapath. The single-cycle opcode decoder asserts all datapath controls in one cycle. This block instead walks each instruction through FETCH, DECODE, EXECUTE, MEM and write-back states. It shares one memory port between instruction fetch and data access through a req/ready handshake, and counts retired instructions.

---
 rtl/multicycle_control.sv | 216 +++++++++++++++++++++
 tb/tb_multicycle_control.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// multicycle_control
//
// Sequencing controller for the multi-cycle RISC-V datapath. Each instruction
// walks through FETCH -> DECODE -> EXECUTE -> (MEM) -> (write-back). The
// instruction fetch and data accesses share one memory port. A transfer
// completes on a cycle where mem_req and mem_ready are both high.
// A counter records the number of retired instructions.
//
// Optional feature: MULTICYCLE_ILLEGAL_TRAP_EN
//   defined   : an unknown opcode in EXECUTE enters TRAP and sets illegal_insn.
//               The block then stays in TRAP until reset.
//   undefined : an unknown opcode is treated as a NOP that does not retire.
//
// Ports
//   clk, rst_n    : clock, synchronous active-low reset
//   opcode        : IR[6:0]
//   zero          : ALU zero flag (sampled in EXECUTE for branches)
//   mem_ready     : memory handshake completion
//   mem_req/mem_we/iord         : memory port control
//   ir_write/pc_write/pc_src    : IR and PC control
//   alu_src_a/alu_src_b/alu_op  : ALU operand and operation selects
//   reg_write/mem_to_reg        : register file write-back control
//   state         : current state (debug)
//   retired       : retired-instruction count (wraps)
//   illegal_insn  : sticky illegal-opcode flag
module multicycle_control #(
  parameter int RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [6:0]          opcode,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                mem_we,
  output logic                iord,
  output logic                ir_write,
  output logic                pc_write,
  output logic                pc_src,
  output logic [1:0]          alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          alu_op,
  output logic                reg_write,
  output logic                mem_to_reg,
  output logic [2:0]          state,
  output logic [RETIRE_W-1:0] retired,
  output logic                illegal_insn
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_WB_ALU  = 3'd4,
    S_WB_MEM  = 3'd5,
    S_TRAP    = 3'd6
  } state_t;

  state_t              state_reg, state_next;
  logic [RETIRE_W-1:0] retired_reg;
  logic                retire;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= S_FETCH;
      retired_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (retire)
        retired_reg <= retired_reg + {{(RETIRE_W-1){1'b0}}, 1'b1};
    end
  end

`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
  logic illegal_reg;

  // Sticky flag. It is raised on the same edge that enters TRAP.
  always_ff @(posedge clk) begin
    if (!rst_n)
      illegal_reg <= 1'b0;
    else if (state_next == S_TRAP)
      illegal_reg <= 1'b1;
  end

  assign illegal_insn = illegal_reg;
`else
  assign illegal_insn = 1'b0;
`endif

  assign state   = state_reg;
  assign retired = retired_reg;

  always_comb begin
    state_next = state_reg;
    retire     = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    alu_src_a  = 2'd0;
    alu_src_b  = 2'd0;
    alu_op     = 2'b00;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;

    case (state_reg)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'd1;
        if (mem_ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        // Branch target (old PC + imm) is computed into ALUOut here.
        alu_src_a  = 2'd2;
        alu_src_b  = 2'd2;
        state_next = S_EXECUTE;
      end
      S_EXECUTE: begin
        case (opcode)
          OP_R: begin
            alu_src_a  = 2'd1;
            alu_op     = 2'b10;
            state_next = S_WB_ALU;
          end
          OP_I: begin
            alu_src_a  = 2'd1;
            alu_src_b  = 2'd2;
            alu_op     = 2'b10;
            state_next = S_WB_ALU;
          end
          OP_LOAD, OP_STORE: begin
            alu_src_a  = 2'd1;
            alu_src_b  = 2'd2;
            state_next = S_MEM;
          end
          OP_BRANCH: begin
            alu_src_a  = 2'd1;
            alu_op     = 2'b01;
            pc_src     = 1'b1;
            pc_write   = zero;
            retire     = 1'b1;
            state_next = S_FETCH;
          end
          default: begin
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
            state_next = S_TRAP;
`else
            state_next = S_FETCH;
`endif
          end
        endcase
      end
      S_MEM: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        mem_we  = (opcode == OP_STORE);
        if (mem_ready) begin
          if (opcode == OP_STORE) begin
            retire     = 1'b1;
            state_next = S_FETCH;
          end else begin
            state_next = S_WB_MEM;
          end
        end
      end
      S_WB_ALU: begin
        reg_write  = 1'b1;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_TRAP: begin
        state_next = S_TRAP;
      end
      default: begin
        state_next = S_FETCH;
      end
    endcase

    // Reset silences every strobe immediately, without waiting for a clock edge.
    if (!rst_n) begin
      state_next = S_FETCH;
      retire     = 1'b0;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      iord       = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 1'b0;
      alu_src_a  = 2'd0;
      alu_src_b  = 2'd0;
      alu_op     = 2'b00;
      reg_write  = 1'b0;
      mem_to_reg = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed testbench for multicycle_control.
// It checks the per-cycle state and strobe outputs, and it also checks
// the retired-instruction counter.
module tb_multicycle_control;

  localparam int RW = 4;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_BAD    = 7'b1111111;

  // Strobe bundle order: {mem_req, mem_we, ir_write, pc_write, reg_write}
  localparam logic [4:0] S_NONE  = 5'b00000;
  localparam logic [4:0] S_FETCH = 5'b10110;
  localparam logic [4:0] S_FWAIT = 5'b10000;
  localparam logic [4:0] S_LDMEM = 5'b10000;
  localparam logic [4:0] S_STMEM = 5'b11000;
  localparam logic [4:0] S_WB    = 5'b00001;
  localparam logic [4:0] S_PCW   = 5'b00010;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [6:0]    opcode;
  logic          zero;
  logic          mem_ready;
  logic          mem_req, mem_we, iord, ir_write, pc_write, pc_src;
  logic [1:0]    alu_src_a, alu_src_b, alu_op;
  logic          reg_write, mem_to_reg;
  logic [2:0]    state;
  logic [RW-1:0] retired;
  logic          illegal_insn;

  int checks   = 0;
  int failures = 0;

  multicycle_control #(.RETIRE_W(RW)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .state(state),
    .retired(retired), .illegal_insn(illegal_insn)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] strobes();
    return {mem_req, mem_we, ir_write, pc_write, reg_write};
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Check the current cycle's state and strobes, then advance one cycle.
  task automatic cyc(input string tag, input logic [2:0] st, input logic [4:0] stb);
    #1;
    chk({tag, ".state"}, 32'(state), 32'(st));
    chk({tag, ".strobes"}, 32'(strobes()), 32'(stb));
    tick();
  endtask

  initial begin
    rst_n     = 1'b0;
    mem_ready = 1'b1;
    zero      = 1'b0;
    opcode    = OP_R;

    // Reset held for three cycles with mem_ready high.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst.state", 32'(state), 32'd0);
      chk("rst.retired", 32'(retired), 32'd0);
      chk("rst.strobes", 32'(strobes()), 32'(S_NONE));
      chk("rst.illegal", 32'(illegal_insn), 32'd0);
    end
    rst_n = 1'b1;
    #1;
    chk("rel.mem_req", 32'(mem_req), 32'd1);

    // R-type, then load, then store, all with zero wait states.
    cyc("r.fetch", 3'd0, S_FETCH);
    cyc("r.decode", 3'd1, S_NONE);
    #1;
    chk("r.ex.alu", 32'({alu_src_a, alu_src_b, alu_op}), 32'b01_00_10);
    cyc("r.exec", 3'd2, S_NONE);
    #1;
    chk("r.wb.m2r", 32'(mem_to_reg), 32'd0);
    cyc("r.wb", 3'd4, S_WB);

    opcode = OP_LOAD;
    cyc("ld.fetch", 3'd0, S_FETCH);
    cyc("ld.decode", 3'd1, S_NONE);
    #1;
    chk("ld.ex.alu", 32'({alu_src_a, alu_src_b, alu_op}), 32'b01_10_00);
    cyc("ld.exec", 3'd2, S_NONE);
    #1;
    chk("ld.mem.iord", 32'(iord), 32'd1);
    cyc("ld.mem", 3'd3, S_LDMEM);
    #1;
    chk("ld.wb.m2r", 32'(mem_to_reg), 32'd1);
    cyc("ld.wb", 3'd5, S_WB);

    opcode = OP_STORE;
    cyc("st.fetch", 3'd0, S_FETCH);
    cyc("st.decode", 3'd1, S_NONE);
    cyc("st.exec", 3'd2, S_NONE);
    cyc("st.mem", 3'd3, S_STMEM);
    chk("b2b.retired", 32'(retired), 32'd3);

    // Taken branch.
    opcode = OP_BRANCH;
    zero   = 1'b1;
    cyc("bt.fetch", 3'd0, S_FETCH);
    cyc("bt.decode", 3'd1, S_NONE);
    #1;
    chk("bt.pc_src", 32'(pc_src), 32'd1);
    chk("bt.ex.alu", 32'({alu_src_a, alu_src_b, alu_op}), 32'b01_00_01);
    cyc("bt.exec", 3'd2, S_PCW);
    chk("bt.retired", 32'(retired), 32'd4);

    // Branch that is not taken.
    zero = 1'b0;
    cyc("bn.fetch", 3'd0, S_FETCH);
    cyc("bn.decode", 3'd1, S_NONE);
    cyc("bn.exec", 3'd2, S_NONE);
    chk("bn.retired", 32'(retired), 32'd5);

    // Load with wait states: 2 cycles in FETCH and 3 cycles in MEM.
    opcode    = OP_LOAD;
    mem_ready = 1'b0;
    cyc("ws.fwait0", 3'd0, S_FWAIT);
    cyc("ws.fwait1", 3'd0, S_FWAIT);
    mem_ready = 1'b1;
    cyc("ws.fetch", 3'd0, S_FETCH);
    cyc("ws.decode", 3'd1, S_NONE);
    cyc("ws.exec", 3'd2, S_NONE);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) cyc("ws.mwait", 3'd3, S_LDMEM);
    mem_ready = 1'b1;
    cyc("ws.mem", 3'd3, S_LDMEM);
    cyc("ws.wb", 3'd5, S_WB);
    chk("ws.retired", 32'(retired), 32'd6);

    // Illegal opcode.
    opcode = OP_BAD;
    cyc("il.fetch", 3'd0, S_FETCH);
    cyc("il.decode", 3'd1, S_NONE);
    cyc("il.exec", 3'd2, S_NONE);
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    for (int i = 0; i < 20; i++) begin
      chk("il.trap.flag", 32'(illegal_insn), 32'd1);
      chk("il.trap.retired", 32'(retired), 32'd6);
      cyc("il.trap", 3'd6, S_NONE);
    end
`else
    chk("il.nop.flag", 32'(illegal_insn), 32'd0);
    chk("il.nop.retired", 32'(retired), 32'd6);
    cyc("il.nop.fetch", 3'd0, S_FETCH);
`endif

    // Clear the counter, then retire 17 R-type instructions to wrap the 4-bit counter.
    rst_n = 1'b0;
    tick();
    chk("rst2.retired", 32'(retired), 32'd0);
    chk("rst2.flag", 32'(illegal_insn), 32'd0);
    rst_n  = 1'b1;
    opcode = OP_R;
    for (int i = 0; i < 17; i++) begin
      cyc("wr.fetch", 3'd0, S_FETCH);
      cyc("wr.decode", 3'd1, S_NONE);
      cyc("wr.exec", 3'd2, S_NONE);
      cyc("wr.wb", 3'd4, S_WB);
      chk("wr.retired", 32'(retired), 32'((i + 1) % 16));
    end
    chk("wrap.retired", 32'(retired), 32'd1);

    // Apply reset while a store is waiting in MEM.
    opcode = OP_STORE;
    cyc("ab.fetch", 3'd0, S_FETCH);
    cyc("ab.decode", 3'd1, S_NONE);
    cyc("ab.exec", 3'd2, S_NONE);
    mem_ready = 1'b0;
    cyc("ab.mwait", 3'd3, S_STMEM);
    rst_n = 1'b0;
    #1;
    chk("ab.rst.strobes", 32'(strobes()), 32'(S_NONE));
    tick();
    cyc("ab.rst0", 3'd0, S_NONE);
    rst_n = 1'b1;
    cyc("ab.rel", 3'd0, S_FWAIT);
    chk("ab.retired", 32'(retired), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
